// File: rtl/rand_seq_pkg.sv
// Shared definitions for the 4-bit pseudo-random sequence: the ordered cycle,
// checker FSM states and the successor lookup used by checker and generator benches.
package rand_seq_pkg;

  localparam int SEQ_LEN = 9;
  localparam logic [3:0] SEQ [SEQ_LEN] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd9,
                                           4'd13, 4'd14, 4'd11, 4'd4};

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] next;
  } succ_t;

  // Codes outside the cycle report legal=0 and a don't-care successor of 0.
  function automatic succ_t seq_succ(input logic [3:0] v);
    succ_t r;
    r.legal = 1'b1;
    r.next  = 4'd0;
    case (v)
      4'd0:    r.next = 4'd1;
      4'd1:    r.next = 4'd6;
      4'd6:    r.next = 4'd8;
      4'd8:    r.next = 4'd9;
      4'd9:    r.next = 4'd13;
      4'd13:   r.next = 4'd14;
      4'd14:   r.next = 4'd11;
      4'd11:   r.next = 4'd4;
      4'd4:    r.next = 4'd0;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rand_seq_succ.sv
// Combinational successor lookup for one sequence code.
module rand_seq_succ
  import rand_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic       legal,
  output logic [3:0] next
);

  succ_t s;

  assign s     = seq_succ(din);
  assign legal = s.legal;
  assign next  = s.next;

endmodule

// File: rtl/rand_seq_checker.sv
// Lock/flywheel checker for the generator sequence: acquires lock after a run of
// correct successors, rides through isolated glitches, and counts errors and periods.
module rand_seq_checker
  import rand_seq_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERRW       = 8,
  parameter int CYCW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_valid,
  input  logic [3:0]      din,
  output logic            locked,
  output logic            err_pulse,
  output logic            illegal,
  output logic            period_done,
  output logic [ERRW-1:0] err_count,
  output logic [CYCW-1:0] cycle_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  state_t        state, state_d;
  logic [3:0]    prev, prev_d;
  logic [MW-1:0] match_cnt, match_d;
  logic [UW-1:0] miss_cnt, miss_d;
  logic          err_d, illegal_d, period_d;
  logic          din_legal;
  logic [3:0]    din_next;
  logic [3:0]    prev_next;
  logic          unused_din_next;

  rand_seq_succ u_din_succ (
    .din   (din),
    .legal (din_legal),
    .next  (din_next)
  );

  assign unused_din_next = ^din_next;
  assign prev_next       = seq_succ(prev).next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    prev_d    = prev;
    match_d   = match_cnt;
    miss_d    = miss_cnt;
    err_d     = 1'b0;
    illegal_d = 1'b0;
    period_d  = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (din_legal) begin
            prev_d  = din;
            match_d = '0;
            state_d = VERIFY;
          end else begin
            illegal_d = 1'b1;
          end
        end
        VERIFY: begin
          if (!din_legal) begin
            illegal_d = 1'b1;
            state_d   = HUNT;
          end else if (din == prev_next) begin
            match_d = match_cnt + 1'b1;
            prev_d  = din;
            if (match_d == MW'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            prev_d  = din;
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the expected code advances whatever was actually sampled.
          prev_d = prev_next;
          if (din == prev_next) begin
            miss_d   = '0;
            period_d = (din == 4'd0);
          end else begin
            err_d     = 1'b1;
            illegal_d = !din_legal;
            miss_d    = miss_cnt + 1'b1;
            if (miss_d == UW'(UNLOCK_CNT)) begin
              state_d = HUNT;
              miss_d  = '0;
              match_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev        <= 4'd0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      illegal     <= 1'b0;
      period_done <= 1'b0;
      err_count   <= '0;
      cycle_count <= '0;
    end else begin
      prev        <= prev_d;
      match_cnt   <= match_d;
      miss_cnt    <= miss_d;
      locked      <= (state_d == LOCKED);
      err_pulse   <= err_d;
      illegal     <= illegal_d;
      period_done <= period_d;
      if (err_d && (err_count != '1))
        err_count <= err_count + 1'b1;
      if (period_d && (cycle_count != '1))
        cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rand_seq_checker.sv
// Self-checking bench for rand_seq_checker: directed scenarios plus randomized
// traffic compared against a position-based reference model of the sequence.
module tb_rand_seq_checker;

  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 2;
  localparam int ERRW       = 2;
  localparam int CYCW       = 3;
  localparam int SEQ_LEN    = 9;
  localparam int ERR_MAX    = (1 << ERRW) - 1;
  localparam int CYC_MAX    = (1 << CYCW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            din_valid;
  logic [3:0]      din;
  logic            locked;
  logic            err_pulse;
  logic            illegal;
  logic            period_done;
  logic [ERRW-1:0] err_count;
  logic [CYCW-1:0] cycle_count;

  int seq_tab [SEQ_LEN] = '{0, 1, 6, 8, 9, 13, 14, 11, 4};
  int ill_tab [7]       = '{2, 3, 5, 7, 10, 12, 15};

  // Reference model state: lock is tracked as a position within the cycle.
  bit m_locked, m_have_prev, m_err, m_illegal, m_period;
  int m_pos, m_run, m_miss, m_err_count, m_cyc_count;

  int check_count = 0;
  int pass_count  = 0;
  int seen_ill, seen_err;

  rand_seq_checker #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .ERRW       (ERRW),
    .CYCW       (CYCW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din         (din),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .illegal     (illegal),
    .period_done (period_done),
    .err_count   (err_count),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  function automatic int pos_of(input int v);
    for (int i = 0; i < SEQ_LEN; i++)
      if (seq_tab[i] == v) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_have_prev = 0; m_err = 0; m_illegal = 0; m_period = 0;
    m_pos = 0; m_run = 0; m_miss = 0; m_err_count = 0; m_cyc_count = 0;
  endtask

  task automatic model_step(input bit v, input int d);
    int p, e;
    m_err = 0; m_illegal = 0; m_period = 0;
    if (!v) return;
    p = pos_of(d);
    if (m_locked) begin
      e = (m_pos + 1) % SEQ_LEN;
      m_pos = e;
      if (p == e) begin
        m_miss = 0;
        if (d == 0) begin
          m_period = 1;
          if (m_cyc_count < CYC_MAX) m_cyc_count++;
        end
      end else begin
        m_err = 1;
        if (m_err_count < ERR_MAX) m_err_count++;
        if (p < 0) m_illegal = 1;
        m_miss++;
        if (m_miss == UNLOCK_CNT) begin
          m_locked = 0; m_have_prev = 0; m_run = 0; m_miss = 0;
        end
      end
    end else if (!m_have_prev) begin
      if (p < 0) m_illegal = 1;
      else begin
        m_have_prev = 1; m_pos = p; m_run = 0;
      end
    end else begin
      if (p < 0) begin
        m_illegal = 1; m_have_prev = 0;
      end else if (p == (m_pos + 1) % SEQ_LEN) begin
        m_run++; m_pos = p;
        if (m_run == LOCK_CNT) begin
          m_locked = 1; m_miss = 0;
        end
      end else begin
        m_pos = p; m_run = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    checkOutput({tag, ".locked"},      32'(locked),      32'(m_locked));
    checkOutput({tag, ".err_pulse"},   32'(err_pulse),   32'(m_err));
    checkOutput({tag, ".illegal"},     32'(illegal),     32'(m_illegal));
    checkOutput({tag, ".period_done"}, 32'(period_done), 32'(m_period));
    checkOutput({tag, ".err_count"},   32'(err_count),   32'(m_err_count));
    checkOutput({tag, ".cycle_count"}, 32'(cycle_count), 32'(m_cyc_count));
  endtask

  task automatic applyStimulus(input bit v, input int d);
    din_valid = v;
    din       = 4'(d);
    @(posedge clk);
    #1;
    model_step(v, d);
    check_all("step");
    if (illegal) seen_ill++;
    if (err_pulse) seen_err++;
  endtask

  task automatic feed_seq(input int start, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, seq_tab[(start + i) % SEQ_LEN]);
  endtask

  // Reset lands mid-cycle, checked before the next clock edge arrives.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nxt;
    bit v;
    rst = 1'b1; din_valid = 1'b0; din = 4'd0;
    seen_ill = 0; seen_err = 0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] clean lock and period count");
    feed_seq(0, 4);
    checkOutput("t1_locked_after_4", 32'(locked), 32'd1);
    feed_seq(4, 15);
    checkOutput("t1_cycle_count", 32'(cycle_count), 32'd2);
    checkOutput("t1_err_count", 32'(err_count), 32'd0);

    $display("[TB] single glitch");
    feed_seq(1, 4);
    applyStimulus(1, 12);
    checkOutput("t2_err_pulse", 32'(err_pulse), 32'd1);
    checkOutput("t2_illegal", 32'(illegal), 32'd1);
    checkOutput("t2_err_count", 32'(err_count), 32'd1);
    checkOutput("t2_locked", 32'(locked), 32'd1);
    feed_seq(6, 4);
    checkOutput("t2_err_after", 32'(err_count), 32'd1);

    $display("[TB] double glitch");
    feed_seq(1, 2);
    applyStimulus(1, 9);
    checkOutput("t3_locked_first", 32'(locked), 32'd1);
    applyStimulus(1, 6);
    checkOutput("t3_unlocked", 32'(locked), 32'd0);
    checkOutput("t3_err_count", 32'(err_count), 32'd3);
    feed_seq(5, 3);
    checkOutput("t3_still_hunting", 32'(locked), 32'd0);
    applyStimulus(1, 4);
    checkOutput("t3_relocked", 32'(locked), 32'd1);

    $display("[TB] error counter saturation");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, seq_tab[(m_pos + 2) % SEQ_LEN]);
      applyStimulus(1, seq_tab[(m_pos + 1) % SEQ_LEN]);
    end
    checkOutput("t6_err_sat", 32'(err_count), 32'd3);
    checkOutput("t6_locked", 32'(locked), 32'd1);
    async_reset("t6_async_reset");

    $display("[TB] illegal codes in HUNT");
    seen_ill = 0;
    for (int i = 0; i < 7; i++) applyStimulus(1, ill_tab[i]);
    checkOutput("t4_illegal_pulses", 32'(seen_ill), 32'd7);
    checkOutput("t4_locked", 32'(locked), 32'd0);
    checkOutput("t4_err_count", 32'(err_count), 32'd0);

    $display("[TB] valid gaps");
    seen_ill = 0; seen_err = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1, seq_tab[i % SEQ_LEN]);
      if (i == 3) checkOutput("t5_lock_after_4", 32'(locked), 32'd1);
      applyStimulus(0, int'($urandom_range(0, 15)));
    end
    checkOutput("t5_no_illegal", 32'(seen_ill), 32'd0);
    checkOutput("t5_no_errors", 32'(seen_err), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset("rand_reset");
      v = ($urandom_range(0, 7) != 0);
      nxt = m_have_prev || m_locked ? seq_tab[(m_pos + 1) % SEQ_LEN] : seq_tab[0];
      if ($urandom_range(0, 9) < 8) applyStimulus(v, nxt);
      else applyStimulus(v, int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
